// File: rtl/definitions_pkg.sv
// Shared image geometry, pixel/window widths and the column type used by the
// 3x3 line-window stage.
package definitions_pkg;

    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int PIXEL_W        = 8;
    localparam int WINDOW_W       = 72;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // One vertical slice of the window; index 0 is the oldest (top) line.
    typedef pixel_t [2:0] column_t;

endpackage

// File: rtl/line_window_3x3_line_buffer.sv
// Single-line pixel store: combinational read, synchronous write, no reset.
module line_buffer
    import definitions_pkg::*;
#(
    parameter int DEPTH  = IMG_WIDTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  pixel_t            wdata,
    output pixel_t            rdata
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_window_3x3.sv
// Raster-order pixel stream to 3x3 sliding window, using two line buffers and
// a three-column shift register; windows are emitted only fully inside a frame.
module line_window_3x3
    import definitions_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIXEL_W-1:0]  pixel_in,
    input  logic                pixel_in_valid,
    output logic [WINDOW_W-1:0] window_out,
    output logic                window_out_valid,
    output logic                frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    pixel_t           lb0_rd;
    pixel_t           lb1_rd;
    column_t          col_new;
    column_t          win [3];
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             in_window;

    assign accept    = pixel_in_valid && !rst;
    assign last_col  = (col_cnt == COL_W'(IMG_WIDTH - 1));
    assign last_row  = (row_cnt == ROW_W'(IMG_HEIGHT - 1));
    assign in_window = (row_cnt >= ROW_W'(2)) && (col_cnt >= COL_W'(2));

    // LB1 takes LB0's pre-write value, so the pair acts as a two-line delay.
    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_cnt),
        .wdata (pixel_in),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_cnt),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        col_new    = '0;
        col_new[0] = lb1_rd;
        col_new[1] = lb0_rd;
        col_new[2] = pixel_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt          <= '0;
            row_cnt          <= '0;
            win              <= '{default: '0};
            window_out_valid <= 1'b0;
            frame_done       <= 1'b0;
        end else begin
            window_out_valid <= 1'b0;
            frame_done       <= 1'b0;
            if (accept) begin
                win[0]           <= win[1];
                win[1]           <= win[2];
                win[2]           <= col_new;
                window_out_valid <= in_window;
                frame_done       <= last_row && last_col;
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= last_row ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        window_out = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 3; c++) begin
                window_out[(r*3 + c)*PIXEL_W +: PIXEL_W] = win[c][r];
            end
        end
    end

endmodule

// File: doc/line_window_3x3.md
LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default IMG_WIDTH_DEF (512, from definitions_pkg), meaning pixels per line; legal range >= 3.
REQ-002 SHALL have parameter IMG_HEIGHT, default IMG_HEIGHT_DEF (512, from definitions_pkg), meaning lines per frame; legal range >= 3.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port pixel_in, input, 8 bits, raster-order grayscale pixel.
REQ-006 SHALL have port pixel_in_valid, input, 1 bit, qualifies pixel_in; there is no backpressure.
REQ-007 SHALL have port window_out, output, 72 bits, 3x3 window; byte i = window_out[i*8+:8], i = row*3 + col, row 0 = oldest (top) line, col 0 = leftmost (oldest) pixel; format matches the downstream Gaussian stage input.
REQ-008 SHALL have port window_out_valid, output, 1 bit, one-cycle qualifier per window.
REQ-009 SHALL have port frame_done, output, 1 bit, one-cycle pulse after the last pixel of a frame.

Function
REQ-010 SHALL track col_cnt (0..IMG_WIDTH-1) and row_cnt (0..IMG_HEIGHT-1), advanced only on accepted pixels (pixel_in_valid=1).
REQ-011 SHALL wrap col_cnt to 0 and increment row_cnt after col IMG_WIDTH-1; after (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 (next frame).
REQ-012 SHALL hold two line buffers, LB0 (row r-1) and LB1 (row r-2), each IMG_WIDTH x 8, both addressed by col_cnt.
REQ-013 On each accepted pixel SHALL form column {LB1[col], LB0[col], pixel_in}, then write LB1[col]<=LB0[col] and LB0[col]<=pixel_in in the same cycle.
REQ-014 On each accepted pixel SHALL shift the 3x3 window register left: col0<=col1, col1<=col2, col2<=new column.
REQ-015 SHALL assert window_out_valid exactly one cycle after an accepted pixel with row_cnt>=2 and col_cnt>=2; otherwise window_out_valid=0.
REQ-016 Output image SHALL therefore be (IMG_WIDTH-2) x (IMG_HEIGHT-2) windows per frame; no border padding; no windows straddling a line wrap.
REQ-017 window_out SHALL hold its last value when no pixel is accepted.
REQ-018 Idle cycles (pixel_in_valid=0) at any point SHALL NOT alter counters, buffers, window, or produced window sequence.
REQ-019 frame_done SHALL pulse high one cycle after the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted, coincident with the final window_out_valid.
REQ-020 Line-buffer contents from a previous frame SHALL never reach a valid window (guaranteed by REQ-015 gating).

Reset
REQ-021 While rst=1 at a clock edge SHALL clear col_cnt, row_cnt, window registers, window_out (0), window_out_valid (0), frame_done (0).
REQ-022 Line-buffer storage SHALL NOT require reset.
REQ-023 Reset mid-frame SHALL abandon the frame; the first pixel after rst deasserts is treated as (0,0) of a new frame.

Structure
REQ-024 IMG_WIDTH_DEF, IMG_HEIGHT_DEF, PIXEL_W (8) and WINDOW_W (72) SHALL live in definitions_pkg.
REQ-025 Line storage SHALL be a sub-module line_buffer (depth IMG_WIDTH, 8-bit, combinational read, synchronous write), instantiated twice.
REQ-026 Counter widths SHALL be $clog2 of the respective parameter.

Verification (bench with IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = row*4+col)
REQ-027 Continuous frame of 16 pixels -> exactly 4 windows; first, one cycle after pixel 10, window_out = 0x0A0908060504020100; last = 0x0F0E0D0B0A0907 0605 (bytes 15,14,13,11,10,9,7,6,5).
REQ-028 Same frame with 3 idle cycles between every pixel -> identical 4 windows, each one cycle after its completing pixel; window_out held during gaps.
REQ-029 frame_done -> single pulse one cycle after pixel 15, coincident with the 4th window_out_valid; no other pulses.
REQ-030 Two back-to-back frames (second = 100+idx) -> no window_out_valid during second frame's first 10 pixels; first second-frame window = bytes 110,109,108,106,105,104,102,101,100.
REQ-031 rst asserted for 1 cycle after pixel 6 -> outputs 0 next cycle; new frame (200+idx) gives first window bytes 210..200 pattern only after its 11th pixel; no stale-data window.
REQ-032 rst held high with pixel_in_valid=1 -> window_out_valid and frame_done stay 0, counters stay 0.
